// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg
//   Shared definitions for the SSD1306 OLED controller blocks.
//   Holds the controller opcodes used by the ROM-driven init sequencer and
//   by the frame streamer, the size of the address-window preamble, and the
//   frame-streamer state type.
//   No ports; import with "import ssd1306_pkg::*;".
package ssd1306_pkg;

  // Opcodes issued by the init sequencer before the streamer may run.
  localparam logic [7:0] SET_MEM_MODE    = 8'h20;
  localparam logic [7:0] SET_START_LINE  = 8'h40;
  localparam logic [7:0] SET_CONTRAST    = 8'h81;
  localparam logic [7:0] CHARGE_PUMP     = 8'h8D;
  localparam logic [7:0] SEG_REMAP       = 8'hA1;
  localparam logic [7:0] DISPLAY_RESUME  = 8'hA4;
  localparam logic [7:0] NORMAL_DISPLAY  = 8'hA6;
  localparam logic [7:0] SET_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] DISPLAY_OFF     = 8'hAE;
  localparam logic [7:0] DISPLAY_ON      = 8'hAF;
  localparam logic [7:0] COM_SCAN_DEC    = 8'hC8;
  localparam logic [7:0] SET_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] SET_CLK_DIV     = 8'hD5;
  localparam logic [7:0] SET_PRECHARGE   = 8'hD9;
  localparam logic [7:0] SET_COM_PINS    = 8'hDA;
  localparam logic [7:0] SET_VCOM_DESEL  = 8'hDB;

  // Address-window opcodes used by the frame streamer. Each is followed by
  // a start and an end argument byte.
  localparam logic [7:0] SET_COL_ADDR    = 8'h21;
  localparam logic [7:0] SET_PAGE_ADDR   = 8'h22;

  // The window preamble is col-cmd, col-start, col-end, page-cmd,
  // page-start, page-end; the index of its final byte ends the command phase.
  localparam int         WINDOW_CMD_COUNT = 6;
  localparam logic [2:0] LAST_CMD_IDX     = 3'(WINDOW_CMD_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_LOAD,
    ST_CMD_WAIT,
    ST_FETCH,
    ST_DATA_LOAD,
    ST_DATA_WAIT,
    ST_DONE
  } stream_state_e;

endpackage

// File: rtl/ssd1306_frame_streamer.sv
// ssd1306_frame_streamer
//   Post-init refresh controller for an SSD1306 panel. On an accepted start
//   it drives the shared spi_master byte interface: first the six-byte
//   column/page address window (D/C low), then every frame-buffer byte in
//   linear order (D/C high), one spi_wr strobe per byte, each byte held
//   until spi_master reports it finished.
//
//   Parameters
//     COLS    display width in columns (bytes per page)
//     PAGES   number of 8-row pages
//     ADDR_W  frame-buffer address width, 2**ADDR_W >= COLS*PAGES
//
//   Ports
//     clk, rst    clock shared with spi_master; synchronous active-high reset
//     init_done   level from the init sequencer; gates acceptance of start
//     start       one-cycle refresh request
//     busy        high from accepted start until frame_done
//     frame_done  one-cycle pulse after the last byte completes
//     fb_addr     frame-buffer read address (page*COLS + col)
//     fb_data     frame-buffer read data, one cycle after fb_addr
//     spi_data    byte to spi_master
//     spi_wr      one-cycle write strobe to spi_master
//     spi_done    spi_master end-of-byte pulse
//     oled_dc     0 = command byte, 1 = display data byte
module ssd1306_frame_streamer
  import ssd1306_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int PAGES  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic [7:0]        spi_data,
  output logic              spi_wr,
  input  logic              spi_done,
  output logic              oled_dc
);

  localparam int                FRAME_BYTES = COLS * PAGES;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
  localparam logic [7:0]        LAST_COL    = 8'(COLS - 1);
  localparam logic [7:0]        LAST_PAGE   = 8'(PAGES - 1);

  stream_state_e     state_q, state_d;
  logic [2:0]        cmd_idx_q, cmd_idx_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        spi_data_q, spi_data_d;
  logic              dc_q, dc_d;

  logic              accept;
  logic [2:0]        cmd_sel;
  logic [7:0]        cmd_byte;

  // A start is only honoured when the panel is initialised; otherwise it is
  // simply dropped rather than remembered for later.
  assign accept = start && init_done;

  // The command byte is looked up for the index about to be loaded: index 0
  // when a frame is accepted, idx+1 when a command byte finishes.
  assign cmd_sel = (state_q == ST_CMD_WAIT) ? (cmd_idx_q + 3'd1) : 3'd0;

  // Address window covering the whole panel in horizontal addressing mode.
  always_comb begin
    cmd_byte = 8'h00;
    case (cmd_sel)
      3'd0:    cmd_byte = SET_COL_ADDR;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = LAST_COL;
      3'd3:    cmd_byte = SET_PAGE_ADDR;
      3'd4:    cmd_byte = 8'h00;
      3'd5:    cmd_byte = LAST_PAGE;
      default: cmd_byte = 8'h00;
    endcase
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_idx_q  <= 3'd0;
      byte_cnt_q <= '0;
      spi_data_q <= 8'h00;
      dc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_idx_q  <= cmd_idx_d;
      byte_cnt_q <= byte_cnt_d;
      spi_data_q <= spi_data_d;
      dc_q       <= dc_d;
    end
  end

  // Next-state logic. spi_data_q is loaded one edge ahead of each command
  // strobe so the byte is already on the bus in CMD_LOAD. DONE behaves like
  // IDLE for acceptance so a start in the frame_done cycle is not lost.
  always_comb begin
    state_d    = state_q;
    cmd_idx_d  = cmd_idx_q;
    byte_cnt_d = byte_cnt_q;
    spi_data_d = spi_data_q;
    dc_d       = dc_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d    = ST_CMD_LOAD;
          cmd_idx_d  = 3'd0;
          byte_cnt_d = '0;
          spi_data_d = cmd_byte;
          dc_d       = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD_LOAD: begin
        state_d = ST_CMD_WAIT;
      end

      ST_CMD_WAIT: begin
        if (spi_done) begin
          if (cmd_idx_q == LAST_CMD_IDX) begin
            state_d = ST_FETCH;
            dc_d    = 1'b1;
          end else begin
            state_d    = ST_CMD_LOAD;
            cmd_idx_d  = cmd_idx_q + 3'd1;
            spi_data_d = cmd_byte;
          end
        end
      end

      ST_FETCH: begin
        state_d = ST_DATA_LOAD;
      end

      // The RAM answers during this cycle; capture it so the byte stays put
      // while spi_master shifts it out.
      ST_DATA_LOAD: begin
        state_d    = ST_DATA_WAIT;
        spi_data_d = fb_data;
      end

      // The counter stops on the last address instead of wrapping, so
      // fb_addr still shows the final byte's address after the frame.
      ST_DATA_WAIT: begin
        if (spi_done) begin
          if (byte_cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_FETCH;
            byte_cnt_d = byte_cnt_q + ADDR_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // In DATA_LOAD the fresh RAM word is passed straight through so the data
  // byte is valid in the same cycle as its strobe; afterwards the captured
  // copy holds it steady.
  assign spi_data   = (state_q == ST_DATA_LOAD) ? fb_data : spi_data_q;
  assign spi_wr     = (state_q == ST_CMD_LOAD) || (state_q == ST_DATA_LOAD);
  assign oled_dc    = dc_q;
  assign fb_addr    = byte_cnt_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign frame_done = (state_q == ST_DONE);

endmodule
